// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// It sits on the control unit's alu_valid/alu_ready handshake. It accepts
// funct3 and two operands while IDLE. It then runs one product or quotient
// bit per cycle for XLEN cycles, followed by one sign-fix cycle. After that
// it returns a registered result with a single-cycle alu_ready pulse.
// Divide-by-zero and signed overflow skip the iteration and finish in one
// cycle.
//
// Ports:
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   alu_valid request; held by the initiator until alu_ready is seen
//   alu_ready one-cycle completion pulse; rd is valid in the same cycle
//   funct3    0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1       operand A (multiplicand / dividend)
//   rs2       operand B (multiplier / divisor)
//   rd        registered result, stable from alu_ready until the next accept
//   busy      high whenever the unit is not IDLE
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // Conditional two's-complement negation, used both to take magnitudes
  // and to restore the sign of the result.
  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic [1:0]      state;
  logic [2:0]      op;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] opnd;    // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [XLEN-1:0] acc_hi;  // product high half (mul) or partial remainder (div)
  logic [XLEN-1:0] acc_lo;  // multiplier/product low half (mul) or dividend/quotient (div)
  logic [CW-1:0]   cnt;

  // Operand decode for the accept cycle
  logic            in_signed_a;
  logic            in_signed_b;
  logic            in_sa;
  logic            in_sb;
  logic            div_by_zero;
  logic            div_ovf;

  assign in_signed_a = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                       (funct3 == OP_DIV)  || (funct3 == OP_REM);
  assign in_signed_b = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
  assign in_sa       = in_signed_a & rs1[XLEN-1];
  assign in_sb       = in_signed_b & rs2[XLEN-1];
  assign div_by_zero = funct3[2] && (rs2 == '0);
  assign div_ovf     = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                       (rs1 == MOST_NEG) && (rs2 == ALL_ONES);

  // One iteration step
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right one place.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  // Restoring division: bring in the next dividend bit. The partial
  // remainder is 33 bits wide so the compare never wraps.
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  // The remainder is below the divisor after a subtract, so XLEN bits suffice.
  assign div_diff  = div_shift[XLEN-1:0] - opnd;

  // Sign fix and result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result;

  assign prod_fix = neg_2w({acc_hi, acc_lo}, sign_a ^ sign_b);
  assign quot_fix = neg_w(acc_lo, sign_a ^ sign_b);
  assign rem_fix  = neg_w(acc_hi, sign_a);

  always_comb begin
    result = prod_fix[2*XLEN-1:XLEN];
    if (op == OP_MUL)    result = prod_fix[XLEN-1:0];
    else if (op[2])      result = op[1] ? rem_fix : quot_fix;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      rd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (alu_valid) begin
            op     <= funct3;
            sign_a <= in_sa;
            sign_b <= in_sb;
            cnt    <= '0;
            acc_hi <= '0;
            if (funct3[2]) begin
              opnd   <= neg_w(rs2, in_sb);
              acc_lo <= neg_w(rs1, in_sa);
            end else begin
              opnd   <= neg_w(rs1, in_sa);
              acc_lo <= neg_w(rs2, in_sb);
            end
            // Special cases bypass the iteration; rd is loaded here.
            if (div_by_zero) begin
              rd    <= funct3[1] ? rs1 : ALL_ONES;
              state <= DONE;
            end else if (div_ovf) begin
              rd    <= funct3[1] ? '0 : MOST_NEG;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          rd    <= result;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign alu_ready = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed and random self-checking bench for muldiv_unit.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge. Cycle n is the n-th falling edge after the accepting rising edge.
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        busy;

  int vectors;
  int miscompares;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the ISA definition using native arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive one request, wait (bounded) for alu_ready, then drop alu_valid.
  // lat = -1 when no pulse arrives. idle_after reports that the cycle after
  // the pulse has alu_ready low and the unit idle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic idle_after);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; alu_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (alu_ready) begin lat = n; break; end
    end
    res = rd;
    alu_valid = 1'b0;
    @(negedge clk);
    idle_after = !alu_ready && !busy;
  endtask

  task automatic test_reset;
    resetn = 1'b1; alu_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (rd !== 32'h0 || alu_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: rd=%h ready=%b busy=%b, want rd=0 ready=0 busy=0", rd, alu_ready, busy);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if (alu_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b busy=%b, want 0 0", alu_ready, busy);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  f[4]   = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] exp[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h0000_0006, 32'h0000_0006};
    int lat; logic [31:0] res; logic ok;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], 32'd7, 32'hFFFF_FFFD, lat, res, ok);
      vectors++;
      if (res !== exp[i]) begin
        miscompares++;
        $display("FAIL mul_f%0d_rd: got %h want %h", f[i], res, exp[i]);
      end
      vectors++;
      if (lat != 34) begin
        miscompares++;
        $display("FAIL mul_f%0d_latency: got %0d want 34", f[i], lat);
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL mul_f%0d_pulse: ready/busy still high after pulse, want low", f[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  f[3]   = '{3'd4, 3'd6, 3'd5};
    logic [31:0] exp[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    int lat; logic [31:0] res; logic ok;
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], 32'hFFFF_FFF9, 32'd2, lat, res, ok);
      vectors++;
      if (res !== exp[i]) begin
        miscompares++;
        $display("FAIL div_f%0d_rd: got %h want %h", f[i], res, exp[i]);
      end
      vectors++;
      if (lat != 34) begin
        miscompares++;
        $display("FAIL div_f%0d_latency: got %0d want 34", f[i], lat);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  f[4]   = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] a[4]   = '{32'h0000_0064, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[4]   = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp[4] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h0000_0000};
    int lat; logic [31:0] res; logic ok;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], lat, res, ok);
      vectors++;
      if (res !== exp[i]) begin
        miscompares++;
        $display("FAIL special%0d_rd: got %h want %h", i, res, exp[i]);
      end
      vectors++;
      if (lat != 1) begin
        miscompares++;
        $display("FAIL special%0d_latency: got %0d want 1", i, lat);
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL special%0d_pulse: ready/busy high after pulse, want low", i);
      end
    end
  endtask

  task automatic test_reset_midop;
    int pulses;
    logic [31:0] res; int lat; logic ok;
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; alu_valid = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    alu_valid = 1'b0;
    #1;
    vectors++;
    if (rd !== 32'h0 || alu_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midop_state: rd=%h ready=%b busy=%b, want 0 0 0", rd, alu_ready, busy);
    end
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (alu_ready) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_midop_no_pulse: got %0d pulses want 0", pulses);
    end
    run_op(3'd3, 32'd7, 32'hFFFF_FFFD, lat, res, ok);
    vectors++;
    if (res !== 32'h6 || lat != 34) begin
      miscompares++;
      $display("FAIL reset_midop_next_op: rd=%h lat=%0d want rd=00000006 lat=34", res, lat);
    end
  endtask

  task automatic test_handshake;
    int pulses, lat;
    logic [31:0] res;
    @(negedge clk);
    funct3 = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; alu_valid = 1'b1;
    @(posedge clk);
    pulses = 0; lat = -1; res = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin funct3 = 3'd0; rs1 = 32'h55; rs2 = 32'h99; end
      if (n == 5) alu_valid = 1'b0;
      if (alu_ready) begin
        pulses++;
        if (lat < 0) begin lat = n; res = rd; end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL handshake_pulses: got %0d want 1", pulses);
    end
    vectors++;
    if (res !== 32'hFFFF_FFFD || lat != 34) begin
      miscompares++;
      $display("FAIL handshake_latched: rd=%h lat=%0d want rd=fffffffd lat=34", res, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic [31:0] res1, res2;
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; alu_valid = 1'b1;
    @(posedge clk);
    lat1 = -1; res1 = '0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (alu_ready) begin
        lat1 = n; res1 = rd;
        funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        break;
      end
    end
    vectors++;
    if (res1 !== 32'hFFFF_FFEB || lat1 != 34) begin
      miscompares++;
      $display("FAIL b2b_first: rd=%h lat=%0d want rd=ffffffeb lat=34", res1, lat1);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || alu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: busy=%b ready=%b want 0 0", busy, alu_ready);
    end
    @(posedge clk);
    lat2 = -1; res2 = '0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (alu_ready) begin lat2 = n; res2 = rd; break; end
    end
    alu_valid = 1'b0;
    vectors++;
    if (res2 !== 32'h0000_000E || lat2 != 34) begin
      miscompares++;
      $display("FAIL b2b_second: rd=%h lat=%0d want rd=0000000e lat=34", res2, lat2);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 5))
        0: return 32'h0000_0000;
        1: return 32'hFFFF_FFFF;
        2: return 32'h8000_0000;
        3: return 32'h7FFF_FFFF;
        4: return 32'h0000_0001;
        default: return 32'h0000_0002;
      endcase
    end
    return $urandom;
  endfunction

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b, exp, res;
    int lat, exp_lat;
    logic ok;
    for (int i = 0; i < 1000; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(f, a, b);
      exp_lat = ((f[2] && b == 0) ||
                 ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
      run_op(f, a, b, lat, res, ok);
      vectors++;
      if (res !== exp) begin
        miscompares++;
        $display("FAIL rand%0d_rd f=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, exp);
      end
      vectors++;
      if (lat != exp_lat) begin
        miscompares++;
        $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_lat);
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rand%0d_pulse: ready/busy high after pulse, want low", i);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mul();
    test_div();
    test_reset_midop();
    test_special();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
